decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
Parameterised sequential 1-of-2^SEL_W decoder, the registered successor to the team's 2-to-4 combinational decoder. It accepts select commands over a valid/ready handshake and drives a one-hot output bank in one of three modes: level hold, timed pulse, or auto-scan sweep. It sits between control FSMs and strobe/enable fan-out, for example bank selects, LED/mux scanning and channel strobes.

Parameters:
SEL_W, 2, select width; output width OUT_W = 2**SEL_W (localparam); legal range 1..6
PULSE_LEN, 4, cycles y stays asserted in pulse mode; legal range 1..255
SCAN_DWELL, 8, cycles each output stays asserted in scan mode; legal range 1..255

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low aborts any operation
mode  in  2  00 level, 01 pulse, 10 scan, 11 clear
sel  in  SEL_W  requested output index / scan start index
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
y  out  OUT_W  registered one-hot output (all-zero when idle)
cur_sel  out  SEL_W  index of the currently/last asserted output
active  out  1  OR-reduction of y
done  out  1  one-cycle pulse on normal completion of pulse or scan

Behaviour:
- Reset (rst_n low, async): state IDLE; y=0; cur_sel=0; done=0; dwell/pulse counters=0.
- States: IDLE, LEVEL, PULSE, SCAN.
- cmd_ready = enable & (state==IDLE | state==LEVEL). Combinational from the state register and enable.
- Accept = cmd_valid & cmd_ready. mode and sel are sampled on the accept edge. Latency: y is updated on the clock edge after the accept cycle (1 cycle).
- mode 00: y = 1<<sel, cur_sel = sel, go to LEVEL. Hold until the next accept or until enable drops. A new level accept in LEVEL replaces y directly, with no zero gap.
- mode 01: y = 1<<sel for exactly PULSE_LEN cycles, then go to IDLE. In the cycle y returns to 0: done=1 and cmd_ready=1.
- mode 10: start at index sel. Each index is held SCAN_DWELL cycles, then index = (index+1) mod OUT_W. Exactly OUT_W indices are visited, and the last is (sel-1) mod OUT_W. Then y=0, done=1, go to IDLE. cur_sel tracks the live index.
- mode 11: y=0, go to IDLE. No done. cur_sel is unchanged.
- An accept from LEVEL into PULSE or SCAN takes effect on the next edge with no zero gap.
- enable low in any state: on the next edge y=0 and state=IDLE. No done pulse. Counters clear. cur_sel holds its last value. cmd_valid is ignored while enable is low.
- y is always one-hot or zero, never multi-hot.
- done is never asserted in the same cycle as a nonzero y.
- Counters are 8 bits. Counting is 1..N inclusive of the first asserted cycle.
- SEL_W=1 is legal: OUT_W=2, and a scan visits 2 indices.
- rst_n asserted mid-operation clears immediately (async), with no done. Release is synchronous to clk through the standard deassert sync; the first accept is possible on the first edge after release.

Test Plan:
- Reset/level: SEL_W=2, rst_n low then high; accept mode 00 sel 2 -> next cycle y=0100, active=1, cur_sel=2, cmd_ready=1. Then accept mode 00 sel 1 -> y=0010 with no zero cycle.
- Pulse: PULSE_LEN=4, accept mode 01 sel 3 -> y=1000 for exactly 4 cycles with cmd_ready=0. Next cycle y=0000, done=1 for 1 cycle, cmd_ready=1.
- Scan wrap: SCAN_DWELL=2, accept mode 10 sel 2 -> y sequence 0100,0100,1000,1000,0001,0001,0010,0010, then 0000 with done=1. cur_sel follows 2,3,0,1.
- Abort: during the scan above, drop enable at the third y cycle -> next cycle y=0, no done ever, cmd_ready=0 while enable low. Raise enable -> cmd_ready=1.
- Handshake backpressure: in PULSE, hold cmd_valid=1 with mode 00 sel 0 -> not accepted until cmd_ready=1. It is then accepted in the done cycle, and y=0001 the cycle after.
- Async reset mid-pulse: pull rst_n low between clock edges while y=0010 -> y=0 immediately, done=0. After release, cmd_ready=1.

Source files
------------

// File: rtl/decoder_seq_if.sv
// Command/status bundle for decoder_seq: select handshake in, one-hot bank and status out.
interface decoder_seq_if #(
  parameter int unsigned SEL_W = 2
) ();
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             enable;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] cur_sel;
  logic             active;
  logic             done;

  modport master (
    output enable, mode, sel, cmd_valid,
    input  cmd_ready, y, cur_sel, active, done
  );

  modport slave (
    input  enable, mode, sel, cmd_valid,
    output cmd_ready, y, cur_sel, active, done
  );
endinterface

// File: rtl/decoder_seq.sv
// Registered 1-of-2^SEL_W decoder with level, timed-pulse and auto-scan modes.
module decoder_seq #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned SCAN_DWELL = 8
) (
  input logic          clk,
  input logic          rst_n,
  decoder_seq_if.slave bus
);
  localparam int unsigned      OUT_W     = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] OneHot0   = OUT_W'(1);
  localparam logic [7:0]       PulseLen  = 8'(PULSE_LEN);
  localparam logic [7:0]       ScanDwell = 8'(SCAN_DWELL);
  localparam logic [7:0]       ScanCount = 8'(OUT_W);

  localparam logic [1:0] ModeLevel = 2'b00;
  localparam logic [1:0] ModePulse = 2'b01;
  localparam logic [1:0] ModeScan  = 2'b10;

  typedef enum logic [1:0] {StIdle, StLevel, StPulse, StScan} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] next_idx;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       visit_q, visit_d;
  logic             accept;

  assign bus.cmd_ready = bus.enable & ((state_q == StIdle) | (state_q == StLevel));
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  // Index arithmetic is SEL_W wide, so the scan wraps mod OUT_W for free.
  assign next_idx      = cur_sel_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    visit_d   = visit_q;

    if (!bus.enable) begin
      state_d = StIdle;
      y_d     = '0;
      cnt_d   = 8'd0;
      visit_d = 8'd0;
    end else if (accept) begin
      unique case (bus.mode)
        ModeLevel: begin
          state_d   = StLevel;
          y_d       = OneHot0 << bus.sel;
          cur_sel_d = bus.sel;
          cnt_d     = 8'd0;
          visit_d   = 8'd0;
        end
        ModePulse: begin
          state_d   = StPulse;
          y_d       = OneHot0 << bus.sel;
          cur_sel_d = bus.sel;
          cnt_d     = 8'd1;
          visit_d   = 8'd0;
        end
        ModeScan: begin
          state_d   = StScan;
          y_d       = OneHot0 << bus.sel;
          cur_sel_d = bus.sel;
          cnt_d     = 8'd1;
          visit_d   = 8'd1;
        end
        default: begin
          state_d = StIdle;
          y_d     = '0;
          cnt_d   = 8'd0;
          visit_d = 8'd0;
        end
      endcase
    end else begin
      unique case (state_q)
        StPulse: begin
          if (cnt_q == PulseLen) begin
            state_d = StIdle;
            y_d     = '0;
            done_d  = 1'b1;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StScan: begin
          if (cnt_q != ScanDwell) begin
            cnt_d = cnt_q + 8'd1;
          end else if (visit_q == ScanCount) begin
            state_d = StIdle;
            y_d     = '0;
            done_d  = 1'b1;
            cnt_d   = 8'd0;
            visit_d = 8'd0;
          end else begin
            cur_sel_d = next_idx;
            y_d       = OneHot0 << next_idx;
            cnt_d     = 8'd1;
            visit_d   = visit_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= '0;
      cur_sel_q <= '0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
      visit_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      cur_sel_q <= cur_sel_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      visit_q   <= visit_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.active  = |y_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: SEL_W=2, PULSE_LEN=4, SCAN_DWELL=2.
module tb_decoder_seq;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned PULSE_LEN  = 4;
  localparam int unsigned SCAN_DWELL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_seq_if #(.SEL_W(SEL_W)) bus ();

  decoder_seq #(
    .SEL_W     (SEL_W),
    .PULSE_LEN (PULSE_LEN),
    .SCAN_DWELL(SCAN_DWELL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] cs;
    logic       act;
    logic       done;
    logic       rdy;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic obs_t mk(logic [3:0] y, logic [1:0] cs, logic done, logic rdy);
    return {y, cs, |y, done, rdy};
  endfunction

  function automatic obs_t observe();
    return {bus.y, bus.cur_sel, bus.active, bus.done, bus.cmd_ready};
  endfunction

  task automatic drive(logic v, logic [1:0] m, logic [1:0] s);
    bus.cmd_valid = v;
    bus.mode      = m;
    bus.sel       = s;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    drive(1'b0, 2'b00, 2'd0);
    @(negedge clk);
    e = mk(4'b0000, 2'd0, 1'b0, 1'b0); o = observe(); n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL reset_disabled: got %b expected %b", o, e);
    end
    bus.enable = 1'b1;
    #1;
    e = mk(4'b0000, 2'd0, 1'b0, 1'b1); o = observe(); n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL reset_ready: got %b expected %b", o, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    o = observe(); n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL reset_release: got %b expected %b", o, e);
    end
  endtask

  task automatic test_level();
    obs_t e, o;
    drive(1'b1, 2'b00, 2'd2);
    sb.push_back(mk(4'b0100, 2'd2, 1'b0, 1'b1));
    sb.push_back(mk(4'b0010, 2'd1, 1'b0, 1'b1));
    sb.push_back(mk(4'b0010, 2'd1, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 2'b00, 2'd1);
      else drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL level[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_pulse();
    obs_t e, o;
    drive(1'b1, 2'b01, 2'd3);
    repeat (PULSE_LEN) sb.push_back(mk(4'b1000, 2'd3, 1'b0, 1'b0));
    sb.push_back(mk(4'b0000, 2'd3, 1'b1, 1'b1));
    sb.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL pulse[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t e, o;
    drive(1'b1, 2'b01, 2'd1);
    repeat (PULSE_LEN) sb.push_back(mk(4'b0010, 2'd1, 1'b0, 1'b0));
    sb.push_back(mk(4'b0000, 2'd1, 1'b1, 1'b1));
    sb.push_back(mk(4'b0001, 2'd0, 1'b0, 1'b1));
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b1));
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 2'b00, 2'd0);
      if (i == 5) drive(1'b1, 2'b11, 2'd2);
      if (i == 6) drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL backpressure[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_scan();
    obs_t e, o;
    logic [1:0] idx;
    drive(1'b1, 2'b10, 2'd2);
    idx = 2'd2;
    for (int k = 0; k < 4; k++) begin
      repeat (SCAN_DWELL) sb.push_back(mk(4'(1) << idx, idx, 1'b0, 1'b0));
      idx = idx + 2'd1;
    end
    sb.push_back(mk(4'b0000, 2'd1, 1'b1, 1'b1));
    sb.push_back(mk(4'b0000, 2'd1, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL scan[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_abort();
    obs_t e, o;
    drive(1'b1, 2'b10, 2'd2);
    sb.push_back(mk(4'b0100, 2'd2, 1'b0, 1'b0));
    sb.push_back(mk(4'b0100, 2'd2, 1'b0, 1'b0));
    sb.push_back(mk(4'b1000, 2'd3, 1'b0, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL abort_run[%0d]: got %b expected %b", i, o, e);
      end
    end
    bus.enable = 1'b0;
    drive(1'b1, 2'b00, 2'd1);
    repeat (4) sb.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b0));
    sb.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      if (i == 3) begin
        drive(1'b0, 2'b00, 2'd0);
        bus.enable = 1'b1;
      end
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL abort_off[%0d]: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [1:0] s;
    for (int i = 0; i < 8; i++) begin
      s = 2'($urandom_range(0, 3));
      drive(1'b1, 2'b00, s);
      sb.push_back(mk(4'(1) << s, s, 1'b0, 1'b1));
      @(negedge clk);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL b2b_level[%0d]: got %b expected %b", i, o, e);
      end
    end
    drive(1'b1, 2'b11, 2'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 2'd0);
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    drive(1'b1, 2'b01, 2'd1);
    @(negedge clk);
    drive(1'b0, 2'b00, 2'd0);
    e = mk(4'b0010, 2'd1, 1'b0, 1'b0); o = observe(); n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL areset_pre: got %b expected %b", o, e);
    end
    #2 rst_n = 1'b0;
    #1;
    e = mk(4'b0000, 2'd0, 1'b0, 1'b1); o = observe(); n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL areset_now: got %b expected %b", o, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 2'd3);
    sb.push_back(mk(4'b1000, 2'd3, 1'b0, 1'b1));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'd0);
      e = sb.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL areset_first_accept: got %b expected %b", o, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_backpressure();
    test_scan();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
